// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply / divide unit for the HI/LO path of the CPU. The unit
// accepts a request, iterates one bit per cycle, applies the sign fix-up and
// then publishes the result on hi/lo together with a one-cycle done pulse.
//
// Multiply uses a radix-2 shift-add on operand magnitudes. Divide uses a
// restoring algorithm, also on magnitudes. Latency does not depend on the
// data: zero operands go through every iteration like any other value.
//
// Optional feature macro: MULDIV_DIV_EN
//   defined   : divider datapath is built and DIV/DIVU are fully supported.
//   undefined : no divider logic is built. DIV/DIVU go straight to the
//               fix-up state, keep busy high for one cycle, write hi=lo=0
//               and pulse done.
//
// Parameters:
//   WIDTH  operand width (>= 2); hi and lo are each WIDTH bits
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-low reset
//   fun_c   operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   start   request pulse, honoured only while idle
//   a       multiplicand / dividend (rs)
//   b       multiplier / divisor (rt)
//   hi      product upper half or remainder (registered)
//   lo      product lower half or quotient (registered)
//   busy    operation in progress (registered)
//   done    one-cycle pulse when hi/lo have just been updated (registered)
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       fun_c,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    // Shared working register: {upper accumulator, multiplier} for multiply,
    // {partial remainder, shifting dividend/quotient} for divide.
    logic [2*WIDTH-1:0]   prod;
    // Multiplicand magnitude or divisor magnitude.
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;
    // Sign to apply to the product (multiply) or to the quotient (divide).
    logic                 neg_lo;
`ifdef MULDIV_DIV_EN
    // Remainder takes the sign of the dividend.
    logic                 neg_hi;
`endif

    logic                 acc_sa;
    logic                 acc_sb;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   step_next;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]       shifted;
    logic [WIDTH-1:0]     diff;
    logic [2*WIDTH-1:0]   div_next;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        return neg ? -v : v;
    endfunction

    // Operand signs that matter at acceptance; unsigned ops never negate.
    always_comb begin
        acc_sa = ~fun_c[0] & a[WIDTH-1];
        acc_sb = ~fun_c[0] & b[WIDTH-1];
    end

    // One iteration of each algorithm, computed from the working registers.
    always_comb begin
        sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        // The carry out of the add becomes the new top bit after the shift.
        mul_next = prod[0] ? {sum, prod[WIDTH-1:1]}
                           : {1'b0, prod[2*WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        // Only used when shifted >= opnd, so the difference fits in WIDTH bits.
        diff     = shifted[WIDTH-1:0] - opnd;
        if (shifted >= {1'b0, opnd}) begin
            div_next = {diff, prod[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end
        step_next = is_div ? div_next : mul_next;
`else
        step_next = mul_next;
`endif
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod_signed = neg_lo ? -prod : prod;
        fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fix_lo      = prod_signed[WIDTH-1:0];
        if (is_div) begin
`ifdef MULDIV_DIV_EN
            fix_lo = neg_lo ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
            fix_hi = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
`else
            fix_lo = '0;
            fix_hi = '0;
`endif
        end
    end

    // Control FSM and all registered state. start is only looked at in IDLE,
    // so requests during CALC or FIX are dropped rather than queued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            prod   <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_hi <= 1'b0;
`endif
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        prod   <= {{WIDTH{1'b0}}, magnitude(a, acc_sa)};
                        opnd   <= magnitude(b, acc_sb);
                        is_div <= fun_c[1];
                        neg_lo <= acc_sa ^ acc_sb;
`ifdef MULDIV_DIV_EN
                        neg_hi <= acc_sa;
                        state  <= CALC;
`else
                        state  <= fun_c[1] ? FIX : CALC;
`endif
                        count  <= CW'(WIDTH);
                        busy   <= 1'b1;
                    end
                end
                CALC: begin
                    prod  <= step_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; hi and lo are each WIDTH bits.
REQ-002 The block SHALL have port clock  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port fun_c  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 The block SHALL have port start  input  1  request pulse from the control unit, sampled at a rising edge.
REQ-006 The block SHALL have port a  input  WIDTH  operand A (rs): multiplicand or dividend.
REQ-007 The block SHALL have port b  input  WIDTH  operand B (rt): multiplier or divisor.
REQ-008 The block SHALL have port hi  output  WIDTH  product upper half, or remainder; registered.
REQ-009 The block SHALL have port lo  output  WIDTH  product lower half, or quotient; registered.
REQ-010 The block SHALL have port busy  output  1  operation in progress; the control unit stalls the PC on it; registered.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when hi/lo become valid; the control unit uses it to write the HI/LO registers.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC and FIX.
REQ-013 In IDLE with busy=0, start=1 at a rising edge SHALL latch a, b and fun_c, set busy=1, load the iteration counter with WIDTH, and enter CALC.
REQ-014 Operands and fun_c SHALL be used only as latched; changes on a, b or fun_c after acceptance SHALL have no effect.
REQ-015 CALC SHALL perform one iteration per cycle for exactly WIDTH cycles (radix-2 shift-add for multiply, restoring for divide), then enter FIX.
REQ-016 MULT and DIV SHALL operate on magnitudes; a zero operand SHALL take no shortcut, so latency is data-independent.
REQ-017 FIX SHALL apply the sign correction, load hi/lo, clear busy, pulse done=1 for one cycle, and return to IDLE.
REQ-018 From acceptance, busy SHALL be high for exactly WIDTH+1 cycles (33 at default), and done SHALL be asserted in the first cycle after busy falls.
REQ-019 hi and lo SHALL hold their last result until the next FIX or reset.
REQ-020 Sign rules: product sign = sign(a) XOR sign(b); quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 MULT/MULTU SHALL produce the exact 2*WIDTH-bit product, with {hi,lo} = product.
REQ-022 DIV of -2^31 by -1 SHALL give lo=0x80000000 and hi=0.
REQ-023 Division by zero SHALL give lo=all ones and hi=dividend (magnitude algorithm result, sign-corrected); no trap SHALL be raised.
REQ-024 start while busy=1 SHALL be ignored: no restart, no queuing, and no effect on the operation in flight.
REQ-025 start coinciding with the FIX cycle SHALL be ignored; the request must be reissued when busy=0.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear all internal registers.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no partial result SHALL appear on hi/lo, and no done pulse SHALL be produced.
REQ-028 After reset deasserts, the first start SHALL be accepted on the first rising edge on which it is sampled high.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: the divider datapath SHALL be compiled in and DIV/DIVU SHALL behave as specified above.
REQ-030 Macro MULDIV_DIV_EN undefined: no divider logic SHALL be compiled in; DIV/DIVU SHALL go from IDLE directly to FIX (busy high 1 cycle), write hi=lo=0, and pulse done; MULT/MULTU SHALL be unaffected.

Verification
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start one cycle -> busy high 33 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; operands changed to 0 during CALC -> same result.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, busy high 33 cycles, single done pulse.
REQ-035 MULTU 6*7 with start re-pulsed in CALC cycle 10 -> single done; hi=0, lo=42; no second operation begins.
REQ-036 Reset asserted in CALC cycle 15 -> busy/done/hi/lo = 0 with no clock edge; next MULTU 2*3 -> lo=6 after 33 busy cycles. With MULTU 2*3 -> lo=6 completed and MULTU 6*7 reset in CALC cycle 15, hi=0, lo=0 (not 6) and no done pulse follows.
